// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the femtoRV32 unified-memory port arbiter.
//   state_e  : arbiter sequencing states (IDLE -> ISSUE -> [WAIT] -> DONE).
//   owner_e  : which requester holds the current transaction.
//   FETCH_BE : byte enables driven for every instruction fetch.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational arbitration decision between instruction fetch and
//   load/store. Data wins by default; fetch wins when it is the only
//   requester or when it has been passed over STARVE_MAX times in a row.
// Ports:
//   if_req_i      fetch request
//   d_req_i       data request
//   starve_cnt_i  consecutive data grants made while fetch was pending
//   grant_valid_o at least one requester is asking
//   grant_owner_o winning requester (0 = fetch, 1 = data)
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       if_req_i,
  input  logic       d_req_i,
  input  logic [3:0] starve_cnt_i,
  output logic       grant_valid_o,
  output logic       grant_owner_o
);

  logic fetch_wins;

  always_comb begin
    fetch_wins    = if_req_i && (!d_req_i || (starve_cnt_i >= 4'(STARVE_MAX)));
    grant_valid_o = if_req_i || d_req_i;
    grant_owner_o = fetch_wins ? logic'(OWN_IF) : logic'(OWN_D);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-ported unified memory between the fetch unit and the
//   load/store unit. Each access runs IDLE -> ISSUE -> WAIT (LAT-1 cycles)
//   -> DONE; the winner's request is captured at the IDLE edge so requester
//   inputs are ignored until the next arbitration.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   if_req/if_addr      fetch request and address
//   if_done/if_rdata    fetch completion pulse and instruction word
//   d_req/d_we/d_be/d_addr/d_wdata  data request
//   d_done/d_rdata      data completion pulse and load data
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata  memory command (one mem_en per access)
//   mem_rdata           memory read data, valid LAT cycles after mem_en
//   busy                high whenever not IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned LAT        = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_done,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam logic [2:0] LAT_M1 = 3'(LAT - 1);

  state_e        state_q;
  owner_e        owner_q;
  logic [3:0]    starve_q;
  logic [3:0]    starve_d;
  logic [2:0]    lat_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [3:0]    mem_be_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic          if_done_q;
  logic          d_done_q;
  logic          busy_q;

  logic grant_valid;
  logic grant_owner;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .if_req_i      (if_req),
    .d_req_i       (d_req),
    .starve_cnt_i  (starve_q),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  // Starvation count only moves at an arbitration edge; it counts data
  // grants that overtook a pending fetch and saturates at 15.
  always_comb begin
    starve_d = starve_q;
    if (!if_req || (grant_owner == logic'(OWN_IF))) begin
      starve_d = '0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // The mem_* output registers double as the holding registers: they are
  // loaded at the grant edge and only mem_en/mem_we are cleared afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= '0;
      lat_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          starve_q <= starve_d;
          if (grant_valid) begin
            owner_q  <= owner_e'(grant_owner);
            state_q  <= ISSUE;
            busy_q   <= 1'b1;
            mem_en_q <= 1'b1;
            if (grant_owner == logic'(OWN_D)) begin
              mem_we_q    <= d_we;
              mem_be_q    <= d_be;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
            end else begin
              mem_be_q    <= FETCH_BE;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
            end
          end
        end
        ISSUE: begin
          lat_q <= LAT_M1;
          if (LAT == 1) begin
            state_q   <= DONE;
            if_done_q <= (owner_q == OWN_IF);
            d_done_q  <= (owner_q == OWN_D);
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          lat_q <= lat_q - 3'd1;
          if (lat_q == 3'd1) begin
            state_q   <= DONE;
            if_done_q <= (owner_q == OWN_IF);
            d_done_q  <= (owner_q == OWN_D);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign busy      = busy_q;
  assign if_rdata  = if_done_q ? mem_rdata : '0;
  assign d_rdata   = d_done_q  ? mem_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory of the femtoRV32 core between two requesters: the instruction-fetch unit and the load/store unit.
- Sequences each access through issue, fixed-latency wait and completion.
- Grants data accesses first. A starvation guard periodically forces a fetch grant.
- Sits between the core control/datapath and the memory inside cpu_top.

Parameters:
- AW, 32, address width of all address ports.
- LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata. Legal range 1..7.
- STARVE_MAX, 4, number of consecutive data grants with fetch pending, after which fetch wins the next arbitration. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  AW  fetch address; stable while if_req is high.
- if_done  out  1  one-cycle completion pulse for the fetch.
- if_rdata  out  32  instruction word; valid only when if_done=1.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  store byte enables.
- d_addr  in  AW  data address.
- d_wdata  in  32  store data.
- d_done  out  1  one-cycle completion pulse for the data access.
- d_rdata  out  32  load data; valid only when d_done=1.
- mem_en  out  1  memory access strobe; high exactly one cycle per transaction.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  AW  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid LAT cycles after the mem_en cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset (rst=0 at an edge):
  - state goes to IDLE; owner and starve_cnt are cleared.
  - All outputs are 0: if_done, d_done, mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy.
  - if_rdata and d_rdata are driven 0 outside their done cycle.
  - A transaction in flight is abandoned and no done pulse is ever emitted for it. The core reset re-issues.
- IDLE:
  - No request: stay in IDLE.
  - Any request: latch winner into owner and latch the winner's addr/we/be/wdata into holding registers, then go to ISSUE.
  - Arbitration:
    - Fetch wins if only if_req is high, or if both are high and starve_cnt >= STARVE_MAX.
    - Otherwise data wins.
- ISSUE (1 cycle):
  - mem_en=1 and mem_addr/mem_be/mem_wdata come from the holding registers.
  - mem_we=1 only if owner=data and we=1.
  - A fetch drives mem_be=4'hF and mem_we=0.
  - Latency counter is loaded with LAT-1.
  - Next state: DONE if LAT=1, else WAIT.
- WAIT: decrement the counter; go to DONE when it reaches 0. mem_en=0.
- DONE (1 cycle):
  - The owner's done pulse is 1.
  - The owner's rdata = mem_rdata, passed combinationally. It is defined for stores but don't-care.
  - Next state is IDLE.
  - The requester may keep req high with new inputs for a back-to-back access; the inputs are sampled in IDLE on the next edge.
- Latency: req sampled at edge E0 → mem_en in the cycle after E0 → done LAT cycles after the mem_en cycle. One transaction occupies LAT+2 cycles, IDLE included.
- Stores use the same timing as loads: done LAT cycles after issue. The memory commits the write at the end of the ISSUE cycle.
- starve_cnt (4 bits, saturating at 15) is updated at the IDLE arbitration edge:
  - Grant to data while if_req=1: increment.
  - Grant to fetch: clear.
  - if_req=0: clear.
- Requests that change or drop while not in IDLE are ignored. Their effect waits for the next arbitration.
- Never two done pulses in the same cycle. Never a done pulse without a preceding mem_en.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - owner enum {OWN_IF, OWN_D};
  - the fetch byte-enable constant 4'hF.
- One natural sub-module: mem_arb_pick.
  - Combinational.
  - Inputs: if_req, d_req, starve_cnt, STARVE_MAX.
  - Outputs: grant_valid and grant_owner.
  - Verifiable standalone.
- FSM, counters and holding registers stay in mem_port_arbiter.

Test Plan (LAT=1 unless stated):
- Reset behaviour: hold rst=0 for 2 edges with if_req=1 → mem_en, if_done, d_done and busy remain 0. Release rst → mem_en=1 exactly one cycle later, then if_done the following cycle.
- Fetch only: if_addr=0x10, memory returns 0x00500113 → mem_en with mem_addr=0x10, mem_be=F, mem_we=0. Next cycle: if_done=1, if_rdata=0x00500113.
- Simultaneous requests: if_req=d_req=1, d_we=1, d_addr=0x40, d_be=4'b0011, d_wdata=0xDEADBEEF → data granted first: mem_we=1, mem_be=3, mem_wdata=0xDEADBEEF. Then fetch, 3 cycles after the d_done cycle.
- Starvation guard (STARVE_MAX=4): d_req held high continuously and if_req held high → exactly 4 d_done pulses, then if_done, then data resumes.
- LAT=3 load: d_addr=0x80 → mem_en in cycle 1, d_done in cycle 4, d_rdata equals mem_rdata in cycle 4. No second mem_en during WAIT.
- Reset mid-transaction: assert rst=0 in a WAIT cycle (LAT=3) → no done pulse. After release, busy=0 for at least one cycle and the pending request is re-arbitrated.
